div_tick_gen: RTL and testbench
===============================

# div_tick_gen

Downstream consumer of the free-running divided clock `clk_div`. It samples `clk_div` as a data signal in the `clk` domain and detects its edges. It emits a one-cycle `tick` strobe every `ratio` detected edges. The ratio is reprogrammed through a valid/ready handshake, and a new ratio takes effect only at a tick boundary.

## Interface
- `RATIO_W`, default 8: width of the programmable edge ratio.
- `CNT_W`, default 16: width of the tick counter.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset. The reset is synchronous and active-high; no other reset exists.
- `clk_div`  in  1: divider output. It is a register output in the `clk` domain, so no synchronizer is needed.
- `cfg_valid`  in  1: a new ratio is offered.
- `cfg_ratio`  in  RATIO_W: the offered ratio; 0 means disable.
- `cfg_ready`  out  1: a ratio can be accepted this cycle.
- `tick`  out  1: registered one-cycle strobe.
- `tick_cnt`  out  CNT_W: number of ticks emitted; wraps modulo 2^CNT_W.
- `active`  out  1: high when the state is not IDLE.

## Operation
- Edge detect: `div_q` <= `clk_div`. `rise` = `clk_div & ~div_q`. Event `ev` = `rise` (see Configuration).
- Registers: `ratio_r`, `pend_r`, `evt_cnt` (all RATIO_W), and `state`.
- `cfg_ready` = (state != PEND). A config is accepted when `cfg_valid & cfg_ready`.
- `term` = RUN or PEND, and `ev`, and `evt_cnt == ratio_r-1`.
- IDLE: events are ignored and `evt_cnt` holds 0.
  - Accept with ratio != 0: `ratio_r` <= `cfg_ratio`, `evt_cnt` <= 0, state -> RUN.
  - Accept with ratio == 0: consumed, state stays IDLE.
- RUN: `ev & ~term` increments `evt_cnt`. `term` sets `tick` next cycle and clears `evt_cnt`.
  - Accept without `term`: `pend_r` <= `cfg_ratio`, state -> PEND.
  - Accept on the same cycle as `term`: the tick fires. The new ratio loads immediately and becomes the boundary, so no PEND is entered. The next state is RUN, or IDLE if the ratio is 0.
- PEND: counts like RUN with the old ratio. On `term`: tick fires, `ratio_r` <= `pend_r`, `evt_cnt` <= 0, state -> RUN, or IDLE if `pend_r` == 0.
- Ratio 1: every event produces a tick.
- `tick_cnt` increments by 1 on each cycle where `tick` is high and wraps to 0 after all-ones.

## Timing
- Reset values: `tick`=0, `tick_cnt`=0, `cfg_ready`=1, `active`=0, state IDLE, `div_q`=0, all ratio and count registers 0.
- Edge latency: `clk_div` first high in cycle N means `rise` in cycle N. If that event is the terminal one, `tick`=1 in cycle N+1 only.
- An accepted config is visible in `active` and `cfg_ready` in the next cycle.
- Reset mid-operation: the pending ratio and partial count are discarded and state returns to IDLE. A high `clk_div` right after reset can produce a rise, but it is ignored because the block is in IDLE.
- `tick` is never high on two consecutive cycles unless the ratio is 1 and events occur on consecutive cycles.

## Configuration
- `DIV_TICK_BOTH_EDGES_EN`
  - Defined: `ev` = `rise | fall`, where `fall` = `~clk_div & div_q`. A ratio R ticks every R/2 `clk_div` periods.
  - Undefined: `ev` = `rise` only, and the `fall` logic is absent.

## Structure
- Package `div_pkg`:
  - `div_tick_state_t` enum {IDLE, RUN, PEND}, 2 bits.
  - Default width constants `DIV_RATIO_W`=8 and `DIV_CNT_W`=16.
- Sub-module `div_edge_det`: contains the `div_q` register and produces `rise`/`fall`. It is shared by future consumers of `clk_div`.
- The top level holds the FSM, counters, and handshake.

## Test plan
- Reset, then `clk_div` toggling every 4 clk, no config: `tick` stays 0, `active`=0, `tick_cnt`=0.
- Program ratio 3 with rises every 8 clk: ticks come every 24 clk, each one cycle after the 3rd rise. `tick_cnt` reads 4 after 4 ticks.
- In RUN at ratio 3, program ratio 2 after the 1st rise:
  - `cfg_ready` goes 0 and state is PEND.
  - The next tick comes after the 3rd rise. Ticks then come every 2 rises and `cfg_ready` returns to 1.
- Offer ratio 5 in the same cycle as the terminal rise of ratio 3: the tick fires, and the next tick comes after 5 rises with no PEND.
- Program ratio 0 while running: the pending tick completes, then `active`=0 and no further ticks occur. Assert `rst` mid-count: all outputs return to reset values the next cycle.
- Set `tick_cnt` near wrap with CNT_W=4 and ratio 1: after 16 ticks it reads 0. With `DIV_TICK_BOTH_EDGES_EN`, ratio 2 ticks once per `clk_div` period.

Source files
------------

// File: rtl/div_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and default widths for the divided-clock tick generator.
//   div_tick_state_t : FSM state encoding (IDLE, RUN, PEND), 2 bits
//   DIV_RATIO_W      : default width of the programmable edge ratio
//   DIV_CNT_W        : default width of the emitted-tick counter
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } div_tick_state_t;

  localparam int DIV_RATIO_W = 8;
  localparam int DIV_CNT_W   = 16;

endpackage

// File: rtl/div_tick_gen_edge_det.sv
// -----------------------------------------------------------------------------
// div_edge_det
// Edge detector for clk_div, which is already a register output in the clk
// domain and is therefore sampled directly without a synchronizer.
// Optional feature macro: DIV_TICK_BOTH_EDGES_EN (adds the falling-edge output).
// Ports:
//   clk     in  : rising-edge clock
//   rst     in  : synchronous active-high reset
//   clk_div in  : divider output sampled as data
//   fall    out : clk_div went 1->0 this cycle (only with the macro defined)
//   rise    out : clk_div went 0->1 this cycle (combinational, same cycle)
// -----------------------------------------------------------------------------
module div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
`ifdef DIV_TICK_BOTH_EDGES_EN
  output logic fall,
`endif
  output logic rise
);

  logic div_q;

  // Previous-cycle copy of clk_div; reset low so a high input right after
  // reset reads as a rise (harmless, the consumer sits in IDLE then).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= clk_div;
    end
  end

  // Edge decode against the registered copy.
  always_comb begin
    rise = clk_div & ~div_q;
`ifdef DIV_TICK_BOTH_EDGES_EN
    fall = ~clk_div & div_q;
`endif
  end

endmodule

// File: rtl/div_tick_gen.sv
// -----------------------------------------------------------------------------
// div_tick_gen
// Emits a one-cycle tick every `ratio` detected clk_div edges. The ratio is
// reprogrammed with a valid/ready handshake; a new ratio only takes effect at
// a tick boundary (held in a pending register while one is outstanding).
// Optional feature macro: DIV_TICK_BOTH_EDGES_EN (count both clk_div edges).
// Ports:
//   clk       in  : rising-edge clock
//   rst       in  : synchronous active-high reset
//   clk_div   in  : divider output, clk-domain register
//   cfg_valid in  : new ratio offered
//   cfg_ratio in  : offered ratio (0 = disable)
//   cfg_ready out : ratio can be accepted this cycle (not in PEND)
//   tick      out : registered one-cycle strobe
//   tick_cnt  out : number of ticks emitted, wraps
//   active    out : state is not IDLE
// -----------------------------------------------------------------------------
module div_tick_gen
  import div_pkg::*;
#(
  parameter int RATIO_W = DIV_RATIO_W,
  parameter int CNT_W   = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               tick,
  output logic [CNT_W-1:0]   tick_cnt,
  output logic               active
);

  div_tick_state_t    state_r;
  logic [RATIO_W-1:0] ratio_r;
  logic [RATIO_W-1:0] pend_r;
  logic [RATIO_W-1:0] evt_cnt_r;
  logic               tick_r;
  logic [CNT_W-1:0]   tick_cnt_r;
  logic               cfg_ready_r;
  logic               active_r;

  logic rise_s;
  logic ev_s;
  logic term_s;
  logic accept_s;

`ifdef DIV_TICK_BOTH_EDGES_EN
  logic fall_s;

  div_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .fall    (fall_s),
    .rise    (rise_s)
  );
`else
  div_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .rise    (rise_s)
  );
`endif

  // Event selection, terminal-event detect and handshake acceptance.
  always_comb begin
`ifdef DIV_TICK_BOTH_EDGES_EN
    ev_s = rise_s | fall_s;
`else
    ev_s = rise_s;
`endif
    // cfg_ready_r mirrors (state_r != PEND), so it doubles as the ready term.
    accept_s = cfg_valid & cfg_ready_r;
    // ratio_r is never 0 outside IDLE, so ratio_r-1 cannot underflow here.
    if ((state_r == RUN) || (state_r == PEND)) begin
      term_s = ev_s && (evt_cnt_r == (ratio_r - RATIO_W'(1)));
    end else begin
      term_s = 1'b0;
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ratio_r     <= RATIO_W'(0);
      pend_r      <= RATIO_W'(0);
      evt_cnt_r   <= RATIO_W'(0);
      tick_r      <= 1'b0;
      tick_cnt_r  <= CNT_W'(0);
      cfg_ready_r <= 1'b1;
      active_r    <= 1'b0;
    end else begin
      tick_r <= term_s;
      if (tick_r) begin
        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          evt_cnt_r <= RATIO_W'(0);
          // A zero ratio offered in IDLE is simply consumed.
          if (accept_s && (cfg_ratio != RATIO_W'(0))) begin
            ratio_r  <= cfg_ratio;
            state_r  <= RUN;
            active_r <= 1'b1;
          end
        end
        RUN: begin
          if (term_s) begin
            evt_cnt_r <= RATIO_W'(0);
            // Offer coinciding with the boundary loads directly, no PEND.
            if (accept_s) begin
              ratio_r <= cfg_ratio;
              if (cfg_ratio == RATIO_W'(0)) begin
                state_r  <= IDLE;
                active_r <= 1'b0;
              end
            end
          end else begin
            if (ev_s) begin
              evt_cnt_r <= evt_cnt_r + RATIO_W'(1);
            end
            if (accept_s) begin
              pend_r      <= cfg_ratio;
              state_r     <= PEND;
              cfg_ready_r <= 1'b0;
            end
          end
        end
        PEND: begin
          if (term_s) begin
            evt_cnt_r   <= RATIO_W'(0);
            ratio_r     <= pend_r;
            cfg_ready_r <= 1'b1;
            if (pend_r == RATIO_W'(0)) begin
              state_r  <= IDLE;
              active_r <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end else if (ev_s) begin
            evt_cnt_r <= evt_cnt_r + RATIO_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          evt_cnt_r   <= RATIO_W'(0);
          cfg_ready_r <= 1'b1;
          active_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign tick      = tick_r;
  assign tick_cnt  = tick_cnt_r;
  assign active    = active_r;

endmodule

// File: tb/tb_div_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_div_tick_gen
// Self-checking bench for div_tick_gen. Inputs are driven on the falling edge,
// outputs are compared on the following falling edge against a behavioural
// reference that tracks "events seen since the last tick boundary".
// CNT_W is set to 4 so the tick counter wrap is reachable.
// -----------------------------------------------------------------------------
module tb_div_tick_gen;

  localparam int RATIO_W = 8;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clk_div = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [RATIO_W-1:0] cfg_ratio = '0;
  logic               cfg_ready;
  logic               tick;
  logic [CNT_W-1:0]   tick_cnt;
  logic               active;

  div_tick_gen #(.RATIO_W(RATIO_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .tick_cnt  (tick_cnt),
    .active    (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: mode 0 = disabled, 1 = running, 2 = running with a
  // ratio change waiting for the next boundary.
  int m_mode, m_ratio, m_pend, m_seen, m_ticks;
  bit m_prev_div, m_tick;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit model_event(input bit cd);
    bit r, f;
    r = cd && !m_prev_div;
    f = !cd && m_prev_div;
`ifdef DIV_TICK_BOTH_EDGES_EN
    return r || f;
`else
    return r && !f;
`endif
  endfunction

  // True when the edge produced by driving cd would complete the current ratio.
  function automatic bit model_would_tick(input bit cd);
    return (m_mode != 0) && model_event(cd) && (m_seen + 1 == m_ratio);
  endfunction

  task automatic model_step(input bit r, input bit cd, input bit v, input int cr);
    bit ev, boundary, taken;
    if (r) begin
      m_mode = 0; m_ratio = 0; m_pend = 0; m_seen = 0;
      m_ticks = 0; m_tick = 1'b0; m_prev_div = 1'b0;
    end else begin
      ev       = model_event(cd);
      boundary = model_would_tick(cd);
      taken    = v && (m_mode != 2);
      m_ticks  = (m_ticks + (m_tick ? 1 : 0)) % (1 << CNT_W);
      m_tick   = boundary;
      if (boundary) begin
        m_seen = 0;
        if (m_mode == 2) begin
          m_ratio = m_pend;
          m_mode  = (m_pend != 0) ? 1 : 0;
        end else if (taken) begin
          m_ratio = cr;
          m_mode  = (cr != 0) ? 1 : 0;
        end
      end else if (m_mode == 0) begin
        if (taken && cr != 0) begin
          m_ratio = cr;
          m_seen  = 0;
          m_mode  = 1;
        end
      end else begin
        if (ev) m_seen = m_seen + 1;
        if (taken) begin
          m_pend = cr;
          m_mode = 2;
        end
      end
      m_prev_div = cd;
    end
  endtask

  // One clock: compare outputs from the last edge, then apply new inputs.
  task automatic do_cycle(input bit r, input bit cd, input bit v, input int cr);
    @(negedge clk);
    if (chk_en) begin
      check_val("tick",      32'(tick),      32'(m_tick));
      check_val("tick_cnt",  32'(tick_cnt),  32'(m_ticks));
      check_val("cfg_ready", 32'(cfg_ready), 32'(m_mode != 2));
      check_val("active",    32'(active),    32'(m_mode != 0));
    end
    rst       = r;
    clk_div   = cd;
    cfg_valid = v;
    cfg_ratio = RATIO_W'(cr);
    model_step(r, cd, v, cr);
    if (r) chk_en = 1'b1;
  endtask

  bit cd_r;
  bit done_r;
  int ticks_seen;

  initial begin
    // Reset, then clk_div toggling every 4 clk with no configuration.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'(i / 4), 1'b0, 0);

    // Ratio 3, rises every 8 clk: four ticks expected in ~100 cycles.
    do_cycle(1'b0, 1'b0, 1'b1, 3);
    ticks_seen = 0;
    for (int i = 0; i < 100; i++) begin
      do_cycle(1'b0, 1'((i / 4) % 2), 1'b0, 0);
      if (tick) ticks_seen++;
    end
    check_val("ratio3_ticks", 32'(ticks_seen), 32'd4);

    // Offer ratio 5 exactly on a terminal rise of ratio 3.
    done_r = 1'b0;
    for (int i = 0; i < 120; i++) begin
      cd_r = 1'((i / 4) % 2);
      if (!done_r && model_would_tick(cd_r)) begin
        do_cycle(1'b0, cd_r, 1'b1, 5);
        done_r = 1'b1;
      end else begin
        do_cycle(1'b0, cd_r, 1'b0, 0);
      end
    end
    check_val("same_cycle_hit", 32'(done_r), 32'd1);

    // Ratio 2 requested mid-count, then disable while running.
    do_cycle(1'b0, 1'b1, 1'b1, 2);
    for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'((i / 4) % 2), 1'b0, 0);
    do_cycle(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 60; i++) do_cycle(1'b0, 1'((i / 4) % 2), 1'b0, 0);

    // Mid-count reset with clk_div high right afterwards.
    do_cycle(1'b0, 1'b0, 1'b1, 4);
    for (int i = 0; i < 13; i++) do_cycle(1'b0, 1'((i / 2) % 2), 1'b0, 0);
    do_cycle(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 1'b0, 0);

    // Ratio 1 with clk_div toggling every cycle: tick_cnt wraps.
    do_cycle(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 80; i++) do_cycle(1'b0, 1'(i % 2), 1'b0, 0);

    // Randomized traffic.
    cd_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) cd_r = ~cd_r;
      do_cycle(($urandom_range(0, 399) == 0), cd_r,
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)));
    end
    do_cycle(1'b0, cd_r, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
